// File: rtl/relu_maxpool2x2_8ch.sv
// ReLU followed by 2x2 stride-2 max pooling over 8 parallel fp32 raster streams.
// Per-channel datapath lives in relu_maxpool2x2_lane; the top owns the raster counters.

module relu_maxpool2x2_lane #(
  parameter int DATA_WIDTH = 32,
  parameter int IMG_WIDTH  = 56,
  parameter int HW         = 5
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  pix_vld,
  input  logic                  col_odd,
  input  logic                  row_odd,
  input  logic [HW-1:0]         col_half,
  input  logic [DATA_WIDTH-1:0] pix_in,
  output logic [DATA_WIDTH-1:0] pool_out
);

  // After ReLU the sign is always 0, so magnitude bits order the values
  // (positive NaN sorts above everything and propagates).
  function automatic logic [DATA_WIDTH-1:0] vmax(input logic [DATA_WIDTH-1:0] a,
                                                 input logic [DATA_WIDTH-1:0] b);
    return (b[DATA_WIDTH-2:0] > a[DATA_WIDTH-2:0]) ? b : a;
  endfunction

  logic [DATA_WIDTH-1:0] act;
  logic [DATA_WIDTH-1:0] hold;
  logic [DATA_WIDTH-1:0] lbuf [IMG_WIDTH/2];

  assign act = pix_in[DATA_WIDTH-1] ? '0 : pix_in;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hold     <= '0;
      pool_out <= '0;
    end else if (pix_vld) begin
      if (!col_odd)
        hold <= act;
      else if (row_odd)
        pool_out <= vmax(vmax(lbuf[col_half], hold), act);
    end
  end

  // Every entry is written on an even row before the odd row reads it.
  always_ff @(posedge clk) begin
    if (pix_vld && col_odd && !row_odd)
      lbuf[col_half] <= vmax(hold, act);
  end

endmodule

module relu_maxpool2x2_8ch #(
  parameter int DATA_WIDTH  = 32,
  parameter int IMG_WIDTH   = 56,
  parameter int IMG_HEIGHT  = 56,
  parameter int NUM_CHANNEL = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  data_valid_in,
  input  logic [DATA_WIDTH-1:0] data_in_0,
  input  logic [DATA_WIDTH-1:0] data_in_1,
  input  logic [DATA_WIDTH-1:0] data_in_2,
  input  logic [DATA_WIDTH-1:0] data_in_3,
  input  logic [DATA_WIDTH-1:0] data_in_4,
  input  logic [DATA_WIDTH-1:0] data_in_5,
  input  logic [DATA_WIDTH-1:0] data_in_6,
  input  logic [DATA_WIDTH-1:0] data_in_7,
  output logic [DATA_WIDTH-1:0] data_out_0,
  output logic [DATA_WIDTH-1:0] data_out_1,
  output logic [DATA_WIDTH-1:0] data_out_2,
  output logic [DATA_WIDTH-1:0] data_out_3,
  output logic [DATA_WIDTH-1:0] data_out_4,
  output logic [DATA_WIDTH-1:0] data_out_5,
  output logic [DATA_WIDTH-1:0] data_out_6,
  output logic [DATA_WIDTH-1:0] data_out_7,
  output logic                  valid_out_pixel,
  output logic                  done
);

  localparam int CW = ($clog2(IMG_WIDTH)  < 1) ? 1 : $clog2(IMG_WIDTH);
  localparam int RW = ($clog2(IMG_HEIGHT) < 1) ? 1 : $clog2(IMG_HEIGHT);
  localparam int HW = ($clog2(IMG_WIDTH/2) < 1) ? 1 : $clog2(IMG_WIDTH/2);

  logic [CW-1:0] col;
  logic [RW-1:0] row;
  logic          last_col, last_row, win_end;
  logic [HW-1:0] col_half;

  logic [NUM_CHANNEL-1:0][DATA_WIDTH-1:0] din;
  logic [NUM_CHANNEL-1:0][DATA_WIDTH-1:0] dout;

  assign din = {data_in_7, data_in_6, data_in_5, data_in_4,
                data_in_3, data_in_2, data_in_1, data_in_0};
  assign {data_out_7, data_out_6, data_out_5, data_out_4,
          data_out_3, data_out_2, data_out_1, data_out_0} = dout;

  assign last_col = (col == CW'(IMG_WIDTH - 1));
  assign last_row = (row == RW'(IMG_HEIGHT - 1));
  assign win_end  = data_valid_in & col[0] & row[0];
  assign col_half = HW'(col >> 1);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      col             <= '0;
      row             <= '0;
      valid_out_pixel <= 1'b0;
      done            <= 1'b0;
    end else begin
      valid_out_pixel <= win_end;
      done            <= win_end & last_col & last_row;
      if (data_valid_in) begin
        if (last_col) begin
          col <= '0;
          row <= last_row ? '0 : row + 1'b1;
        end else begin
          col <= col + 1'b1;
        end
      end
    end
  end

  relu_maxpool2x2_lane #(
    .DATA_WIDTH(DATA_WIDTH),
    .IMG_WIDTH (IMG_WIDTH),
    .HW        (HW)
  ) u_lane [NUM_CHANNEL-1:0] (
    .clk     (clk),
    .reset   (reset),
    .pix_vld (data_valid_in),
    .col_odd (col[0]),
    .row_odd (row[0]),
    .col_half(col_half),
    .pix_in  (din),
    .pool_out(dout)
  );

endmodule

// File: tb/tb_relu_maxpool2x2_8ch.sv
// Bench: a 4x4 instance for directed/gap/reset cases and a default 56x56 instance
// for a large random frame, both checked against a real-valued pooling model.

module tb_relu_maxpool2x2_8ch;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        va = 1'b0, vb = 1'b0;
  logic [31:0] din [8];
  logic [31:0] da  [8];
  logic [31:0] db  [8];
  logic        vo_a, vo_b, dn_a, dn_b;

  int checks = 0, failures = 0;
  int cyc = 0;

  typedef struct packed {
    logic [7:0][31:0] d;
    logic             done;
    int               stamp;
  } rec_t;

  rec_t gq_a[$], gq_b[$];
  int   eq_a[$], eq_b[$];
  logic [31:0] pix [8][56][56];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  relu_maxpool2x2_8ch #(.IMG_WIDTH(4), .IMG_HEIGHT(4)) dut_a (
    .clk(clk), .reset(reset), .data_valid_in(va),
    .data_in_0(din[0]), .data_in_1(din[1]), .data_in_2(din[2]), .data_in_3(din[3]),
    .data_in_4(din[4]), .data_in_5(din[5]), .data_in_6(din[6]), .data_in_7(din[7]),
    .data_out_0(da[0]), .data_out_1(da[1]), .data_out_2(da[2]), .data_out_3(da[3]),
    .data_out_4(da[4]), .data_out_5(da[5]), .data_out_6(da[6]), .data_out_7(da[7]),
    .valid_out_pixel(vo_a), .done(dn_a));

  relu_maxpool2x2_8ch dut_b (
    .clk(clk), .reset(reset), .data_valid_in(vb),
    .data_in_0(din[0]), .data_in_1(din[1]), .data_in_2(din[2]), .data_in_3(din[3]),
    .data_in_4(din[4]), .data_in_5(din[5]), .data_in_6(din[6]), .data_in_7(din[7]),
    .data_out_0(db[0]), .data_out_1(db[1]), .data_out_2(db[2]), .data_out_3(db[3]),
    .data_out_4(db[4]), .data_out_5(db[5]), .data_out_6(db[6]), .data_out_7(db[7]),
    .valid_out_pixel(vo_b), .done(dn_b));

  always @(negedge clk) begin
    rec_t r;
    if (vo_a) begin
      for (int k = 0; k < 8; k++) r.d[k] = da[k];
      r.done = dn_a; r.stamp = cyc; gq_a.push_back(r);
    end
    if (vo_b) begin
      for (int k = 0; k < 8; k++) r.d[k] = db[k];
      r.done = dn_b; r.stamp = cyc; gq_b.push_back(r);
    end
  end

  // Reference: decode fp32 to a real number and take the arithmetic maximum.
  function automatic real f2r(input logic [31:0] x);
    real v;
    int  e;
    e = int'(x[30:23]);
    if (e == 0) v = real'(x[22:0]) * (2.0 ** -149);
    else        v = (1.0 + real'(x[22:0]) / 8388608.0) * (2.0 ** (e - 127));
    return x[31] ? -v : v;
  endfunction

  function automatic logic [31:0] pool_ref(input int ch, input int i, input int j);
    logic [31:0] best, w;
    best = 32'h0;
    for (int dr = 0; dr < 2; dr++)
      for (int dc = 0; dc < 2; dc++) begin
        w = pix[ch][2*i+dr][2*j+dc];
        if (w[31]) w = 32'h0;
        if (f2r(w) > f2r(best)) best = w;
      end
    return best;
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(negedge clk); va = 1'b0; vb = 1'b0; end
  endtask

  task automatic drive_rows(input bit sel, input int w, input int r0, input int r1, input int gap);
    for (int r = r0; r <= r1; r++)
      for (int c = 0; c < w; c++) begin
        while (gap > 0 && $urandom_range(99) < gap) begin
          @(negedge clk); va = 1'b0; vb = 1'b0;
        end
        @(negedge clk);
        for (int k = 0; k < 8; k++) din[k] = pix[k][r][c];
        va = !sel; vb = sel;
        if ((r % 2 == 1) && (c % 2 == 1)) begin
          if (sel) eq_b.push_back(cyc + 1); else eq_a.push_back(cyc + 1);
        end
      end
  endtask

  task automatic check_frame(input bit sel, input int w, input int h);
    rec_t r;
    int   es;
    for (int i = 0; i < h/2; i++)
      for (int j = 0; j < w/2; j++) begin
        checks++;
        assert ((sel ? gq_b.size() : gq_a.size()) > 0) else begin
          failures++;
          $error("FAIL strobe_missing got=0 exp=1 win=%0d,%0d", i, j);
          return;
        end
        if (sel) begin r = gq_b.pop_front(); es = eq_b.pop_front(); end
        else     begin r = gq_a.pop_front(); es = eq_a.pop_front(); end
        for (int k = 0; k < 8; k++)
          chk($sformatf("data_ch%0d_w%0d_%0d", k, i, j), r.d[k], pool_ref(k, i, j));
        chk("done", 32'(r.done), 32'((i == h/2-1) && (j == w/2-1)));
        chk("stamp", r.stamp, es);
      end
  endtask

  task automatic chk_empty(input string tag);
    chk(tag, gq_a.size() + gq_b.size(), 0);
  endtask

  task automatic do_reset();
    @(negedge clk); #2 reset = 1'b1;
    @(negedge clk); reset = 1'b0;
    gq_a.delete(); gq_b.delete(); eq_a.delete(); eq_b.delete();
  endtask

  initial begin
    rec_t r;
    logic [31:0] cvals [8];
    logic [31:0] t0 [16];
    for (int k = 0; k < 8; k++) din[k] = 32'h0;
    repeat (2) @(negedge clk);
    chk("rst_valid_a", 32'(vo_a), 0);
    chk("rst_done_a", 32'(dn_a), 0);
    chk("rst_out0_a", da[0], 0);
    chk("rst_valid_b", 32'(vo_b), 0);
    chk("rst_out7_b", db[7], 0);
    reset = 1'b0;

    // Directed channel-0 frame: negative window and positive NaN in bottom row.
    t0 = '{32'h3F800000, 32'h40000000, 32'hC0400000, 32'h3F000000,
           32'hBF800000, 32'h3E800000, 32'h40800000, 32'hC0A00000,
           32'h80000000, 32'hBF000000, 32'h7FC00000, 32'h3F800000,
           32'hC1000000, 32'hFFC00000, 32'h40400000, 32'h80000000};
    for (int rr = 0; rr < 4; rr++)
      for (int c = 0; c < 4; c++) begin
        pix[0][rr][c] = t0[rr*4+c];
        for (int k = 1; k < 8; k++) pix[k][rr][c] = 32'h0;
      end
    drive_rows(0, 4, 0, 1, 0);
    idle(3);
    chk("dir_cnt_half", gq_a.size(), 2);
    if (gq_a.size() == 2) begin
      r = gq_a.pop_front(); chk("dir_w0", r.d[0], 32'h40000000); chk("dir_w0_done", 32'(r.done), 0);
      chk("dir_w0_stamp", r.stamp, eq_a.pop_front());
      r = gq_a.pop_front(); chk("dir_w1", r.d[0], 32'h40800000); chk("dir_w1_done", 32'(r.done), 0);
      chk("dir_w1_stamp", r.stamp, eq_a.pop_front());
    end
    drive_rows(0, 4, 2, 3, 0);
    idle(3);
    chk("dir_cnt_full", gq_a.size(), 2);
    if (gq_a.size() == 2) begin
      r = gq_a.pop_front(); chk("dir_negwin", r.d[0], 32'h0); chk("dir_negwin_done", 32'(r.done), 0);
      r = gq_a.pop_front(); chk("dir_nan", r.d[0], 32'h7FC00000); chk("dir_nan_done", 32'(r.done), 1);
    end
    eq_a.delete();

    // Constant per channel (ch3 negative), two back-to-back frames.
    cvals = '{32'h00000000, 32'h3F800000, 32'h40000000, 32'hC0400000,
              32'h40800000, 32'h40A00000, 32'h40C00000, 32'h40E00000};
    for (int k = 0; k < 8; k++)
      for (int rr = 0; rr < 4; rr++)
        for (int c = 0; c < 4; c++) pix[k][rr][c] = cvals[k];
    drive_rows(0, 4, 0, 3, 0);
    drive_rows(0, 4, 0, 3, 0);
    idle(3);
    check_frame(0, 4, 4);
    check_frame(0, 4, 4);
    chk_empty("const_extra");

    // Same frame with ~50% input gaps.
    drive_rows(0, 4, 0, 3, 50);
    idle(3);
    check_frame(0, 4, 4);
    chk_empty("gap_extra");

    // Reset after 5 beats: partial frame must vanish.
    drive_rows(0, 4, 0, 0, 0);
    @(negedge clk);
    for (int k = 0; k < 8; k++) din[k] = 32'h7F000000;
    va = 1'b1;
    do_reset();
    va = 1'b0;
    idle(2);
    chk_empty("rst_partial");
    drive_rows(0, 4, 0, 3, 0);
    idle(3);
    check_frame(0, 4, 4);
    chk_empty("rst_extra");

    // Random mixed-sign 4x4 frame with forced ties.
    for (int k = 0; k < 8; k++)
      for (int rr = 0; rr < 4; rr++)
        for (int c = 0; c < 4; c++)
          pix[k][rr][c] = {1'($urandom_range(1)), 8'($urandom_range(100, 150)), 23'($urandom)};
    pix[2][0][0] = 32'h42000000; pix[2][1][1] = 32'h42000000;
    drive_rows(0, 4, 0, 3, 30);
    idle(3);
    check_frame(0, 4, 4);
    chk_empty("rnd4_extra");

    // Random positive 56x56 frame on the default-size instance.
    for (int k = 0; k < 8; k++)
      for (int rr = 0; rr < 56; rr++)
        for (int c = 0; c < 56; c++)
          pix[k][rr][c] = {1'b0, 8'($urandom_range(1, 254)), 23'($urandom)};
    drive_rows(1, 56, 0, 55, 0);
    idle(3);
    check_frame(1, 56, 56);
    chk_empty("big_extra");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
